// File: rtl/seg_pkg.sv
// Shared constants for the lock display segment path: blank code, the
// off pattern and the active-high gfedcba digit table.
package seg_pkg;

  localparam logic [4:0] SEG_BLANK_CODE = 5'd10;
  localparam logic [6:0] SEG_OFF        = 7'h00;

  // Indexed by digit value; entry 0 is the least significant slice.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [6:0] SEG_ZERO = SEG_DIGITS[0];

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment decoder: 5-bit code to active-high gfedcba pattern.
// Codes 10..31 all map to the blank pattern.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [4:0] num,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_OFF;
    if (num < SEG_BLANK_CODE) begin
      pattern = SEG_DIGITS[num[3:0]];
    end
  end

endmodule

// File: rtl/seg_display.sv
// Registered 7-segment driver for one scanned digit; reset shows "0".
// Polarity is applied after decode so the table stays active-high.
module seg_display
  import seg_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] num,
  output logic [6:0] led
);

  localparam logic [6:0] POLARITY = ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [6:0] pattern;

  seg7_decode u_decode (
    .num     (num),
    .pattern (pattern)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= SEG_ZERO ^ POLARITY;
    end else begin
      led <= pattern ^ POLARITY;
    end
  end

endmodule

// File: tb/tb_seg_display.sv
// Directed self-checking bench for seg_display, covering both the common-anode
// and the common-cathode instance.
module tb_seg_display;

  logic       clk;
  logic       rst;
  logic [4:0] num;
  logic [6:0] led;
  logic       rst_hi;
  logic [4:0] num_hi;
  logic [6:0] led_hi;

  int checks;
  int errors;

  logic [6:0] exp_lo [10];

  seg_display #(.ACTIVE_LOW(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .num (num),
    .led (led)
  );

  seg_display #(.ACTIVE_LOW(1'b0)) dut_hi (
    .clk (clk),
    .rst (rst_hi),
    .num (num_hi),
    .led (led_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    num = 5'd7;
    rst = 1'b1;
    #1;
    checks++;
    if (led !== 7'h40) begin
      errors++;
      $display("[TB] FAIL reset_async got %h expected %h", led, 7'h40);
    end
    @(posedge clk);
    #1;
    checks++;
    if (led !== 7'h40) begin
      errors++;
      $display("[TB] FAIL reset_hold got %h expected %h", led, 7'h40);
    end
  endtask

  task automatic test_digits();
    logic [6:0] prev;
    prev = 7'h40;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      num = 5'(i);
      #2;
      checks++;
      if (led !== prev) begin
        errors++;
        $display("[TB] FAIL digit_latency num=%0d got %h expected %h", i, led, prev);
      end
      @(posedge clk);
      #1;
      checks++;
      if (led !== exp_lo[i]) begin
        errors++;
        $display("[TB] FAIL digit num=%0d got %h expected %h", i, led, exp_lo[i]);
      end
      prev = exp_lo[i];
    end
  endtask

  task automatic test_blank();
    logic [4:0] codes [3];
    codes = '{5'd10, 5'd15, 5'd31};
    for (int i = 0; i < 3; i++) begin
      num = codes[i];
      @(posedge clk);
      #1;
      checks++;
      if (led !== 7'h7F) begin
        errors++;
        $display("[TB] FAIL blank num=%0d got %h expected %h", codes[i], led, 7'h7F);
      end
    end
  endtask

  task automatic test_back_to_back();
    num = 5'd10;
    @(posedge clk);
    #1;
    num = 5'd3;
    checks++;
    if (led !== 7'h7F) begin
      errors++;
      $display("[TB] FAIL scan_blank got %h expected %h", led, 7'h7F);
    end
    @(negedge clk);
    checks++;
    if (led !== 7'h7F) begin
      errors++;
      $display("[TB] FAIL scan_mid got %h expected %h", led, 7'h7F);
    end
    @(posedge clk);
    #1;
    checks++;
    if (led !== 7'h30) begin
      errors++;
      $display("[TB] FAIL scan_digit got %h expected %h", led, 7'h30);
    end
  endtask

  task automatic test_reset_mid();
    num = 5'd8;
    @(posedge clk);
    #1;
    checks++;
    if (led !== 7'h00) begin
      errors++;
      $display("[TB] FAIL mid_pre got %h expected %h", led, 7'h00);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (led !== 7'h40) begin
      errors++;
      $display("[TB] FAIL mid_async got %h expected %h", led, 7'h40);
    end
    @(posedge clk);
    #1;
    checks++;
    if (led !== 7'h40) begin
      errors++;
      $display("[TB] FAIL mid_rst_wins got %h expected %h", led, 7'h40);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (led !== 7'h00) begin
      errors++;
      $display("[TB] FAIL mid_release got %h expected %h", led, 7'h00);
    end
  endtask

  task automatic test_active_high();
    @(negedge clk);
    rst_hi = 1'b1;
    #1;
    checks++;
    if (led_hi !== 7'h3F) begin
      errors++;
      $display("[TB] FAIL hi_reset got %h expected %h", led_hi, 7'h3F);
    end
    @(negedge clk);
    rst_hi = 1'b0;
    num_hi = 5'd2;
    @(posedge clk);
    #1;
    checks++;
    if (led_hi !== 7'h5B) begin
      errors++;
      $display("[TB] FAIL hi_digit2 got %h expected %h", led_hi, 7'h5B);
    end
    num_hi = 5'd10;
    @(posedge clk);
    #1;
    checks++;
    if (led_hi !== 7'h00) begin
      errors++;
      $display("[TB] FAIL hi_blank got %h expected %h", led_hi, 7'h00);
    end
    @(negedge clk);
    rst_hi = 1'b1;
    #1;
    checks++;
    if (led_hi !== 7'h3F) begin
      errors++;
      $display("[TB] FAIL hi_reset_async got %h expected %h", led_hi, 7'h3F);
    end
    @(negedge clk);
    rst_hi = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_lo = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    rst    = 1'b0;
    num    = 5'd7;
    rst_hi = 1'b0;
    num_hi = 5'd0;

    test_reset();
    test_digits();
    test_blank();
    test_back_to_back();
    test_reset_mid();
    test_active_high();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
